// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid register.
package pipe_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int CTRL_W_DEFAULT = 16;
  localparam int CNT_W_DEFAULT  = 16;

  // EMPTY: nothing held; FULL: main holds an entry; SKID: main and skid both hold one.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // The block can take a new entry unless both storage registers are occupied.
  function automatic logic state_accepts(input pipe_state_t s);
    return (s != SKID);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Next count: clear first, otherwise step up unless already at all-ones.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered IN_READY,
// flush, zero-gated control output and a back-pressure cycle counter.
module pipe_skid_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W_DEFAULT,
  parameter int CTRL_W = pipe_pkg::CTRL_W_DEFAULT,
  parameter int CNT_W  = pipe_pkg::CNT_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  input  logic              CNT_CLR,
  output logic [CNT_W-1:0]  STALL_CNT
);

  import pipe_pkg::*;

  pipe_state_t       state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic              in_ready_reg;

  logic out_valid;
  logic in_xfer;
  logic out_xfer;
  logic stall;

  assign out_valid = (state_reg != EMPTY);
  assign in_xfer   = IN_VALID && in_ready_reg;
  assign out_xfer  = out_valid && OUT_READY;
  assign stall     = out_valid && !OUT_READY;

  // Next-state and storage-load decisions; FLUSH overrides everything and
  // discards any entry offered in the same cycle.
  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;

    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          state_next     = FULL;
          main_data_next = IN_DATA;
          main_ctrl_next = IN_CTRL;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          main_data_next = IN_DATA;
          main_ctrl_next = IN_CTRL;
        end else if (in_xfer) begin
          state_next     = SKID;
          skid_data_next = IN_DATA;
          skid_ctrl_next = IN_CTRL;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        if (out_xfer) begin
          state_next     = FULL;
          main_data_next = skid_data_reg;
          main_ctrl_next = skid_ctrl_reg;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    if (FLUSH) begin
      state_next     = EMPTY;
      main_data_next = main_data_reg;
      main_ctrl_next = main_ctrl_reg;
      skid_data_next = skid_data_reg;
      skid_ctrl_next = skid_ctrl_reg;
    end
  end

  // State, storage and the registered ready flag (derived from next state so
  // OUT_READY never reaches IN_READY combinationally).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      in_ready_reg  <= state_accepts(state_next);
    end
  end

  assign IN_READY  = in_ready_reg;
  assign OUT_VALID = out_valid;
  assign OUT_DATA  = main_data_reg;
  assign OUT_CTRL  = out_valid ? main_ctrl_reg : '0;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (stall),
    .clr   (CNT_CLR),
    .count (STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: the reference is an ordered queue of
// accepted entries (capacity two) plus an integer stall count.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA = '0;
  logic [CW-1:0] IN_CTRL = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic [CW-1:0] OUT_CTRL;
  logic          CNT_CLR = 1'b0;
  logic [NW-1:0] STALL_CNT;

  int checks = 0;
  int errors = 0;

  logic [DW+CW-1:0] sb[$];
  int stall_exp = 0;

  pipe_skid_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_CTRL   (IN_CTRL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CTRL  (OUT_CTRL),
    .CNT_CLR   (CNT_CLR),
    .STALL_CNT (STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; returns at posedge+2 with outputs settled.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, input logic clr);
    IN_VALID  = iv;
    IN_DATA   = d;
    IN_CTRL   = c;
    OUT_READY = ordy;
    FLUSH     = fl;
    CNT_CLR   = clr;
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: mid-cycle, compare DUT against the queue model, then apply the
  // effects of the coming rising edge to the model.
  always @(negedge CLK) begin
    int occ;
    logic [DW+CW-1:0] head;
    if (!RST_N) begin
      sb.delete();
      stall_exp = 0;
      check("rst_in_ready", 64'(IN_READY), 64'd1);
      check("rst_out_valid", 64'(OUT_VALID), 64'd0);
      check("rst_out_data", 64'(OUT_DATA), 64'd0);
      check("rst_out_ctrl", 64'(OUT_CTRL), 64'd0);
      check("rst_stall_cnt", 64'(STALL_CNT), 64'd0);
    end else begin
      occ = sb.size();
      check("out_valid", 64'(OUT_VALID), 64'(occ > 0));
      check("in_ready", 64'(IN_READY), 64'(occ < 2));
      check("stall_cnt", 64'(STALL_CNT), 64'(stall_exp));
      if (occ > 0) begin
        head = sb[0];
        check("out_data", 64'(OUT_DATA), 64'(head[DW+CW-1:CW]));
        check("out_ctrl", 64'(OUT_CTRL), 64'(head[CW-1:0]));
      end else begin
        check("out_ctrl_zero", 64'(OUT_CTRL), 64'd0);
      end

      if (CNT_CLR) stall_exp = 0;
      else if (occ > 0 && !OUT_READY && stall_exp < CNT_MAX) stall_exp++;

      if (occ > 0 && OUT_READY) begin
        head = sb.pop_front();
        $display("deliver data=%0h ctrl=%0h", head[DW+CW-1:CW], head[CW-1:0]);
      end
      if (FLUSH) begin
        sb.delete();
      end else if (IN_VALID && occ < 2) begin
        sb.push_back({IN_DATA, IN_CTRL});
        $display("accept  data=%0h ctrl=%0h", IN_DATA, IN_CTRL);
      end
    end
  end

  initial begin
    // Hold reset across two edges, release between edges.
    @(posedge CLK); @(posedge CLK); #2;
    RST_N = 1'b1;

    // Single accept: visible next cycle, ready stays high.
    drive(1'b1, 32'h11, 16'h0101, 1'b1, 1'b0, 1'b0);
    check("lat_valid", 64'(OUT_VALID), 64'd1);
    check("lat_data", 64'(OUT_DATA), 64'h11);
    check("lat_ready", 64'(IN_READY), 64'd1);
    idle(2);

    // Back-to-back stream with no back-pressure.
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 16'(16'h0a00 + i), 1'b1, 1'b0, 1'b0);
    idle(2);
    check("stream_stall", 64'(STALL_CNT), 64'd0);

    // Fill both registers, then drain in order.
    drive(1'b1, 32'hA, 16'h00A5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 16'h00B5, 1'b0, 1'b0, 1'b0);
    check("skid_ready", 64'(IN_READY), 64'd0);
    check("skid_data", 64'(OUT_DATA), 64'hA);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("skid_next_data", 64'(OUT_DATA), 64'hB);
    check("skid_ready_back", 64'(IN_READY), 64'd1);
    idle(2);

    // Flush while SKID with a new entry offered.
    drive(1'b1, 32'hA, 16'h00A5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 16'h00B5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 16'h00C5, 1'b0, 1'b1, 1'b0);
    check("flush_valid", 64'(OUT_VALID), 64'd0);
    check("flush_ctrl", 64'(OUT_CTRL), 64'd0);
    check("flush_ready", 64'(IN_READY), 64'd1);
    idle(3);

    // Long stall saturates the 4-bit counter, then clear wins over a stall.
    drive(1'b1, 32'h77, 16'h0077, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt", 64'(STALL_CNT), 64'(CNT_MAX));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("clr_cnt", 64'(STALL_CNT), 64'd0);
    idle(2);

    // Randomized traffic with occasional flush and counter clear.
    for (int i = 0; i < 400; i++) begin
      drive(1'b1 && ($urandom_range(0, 99) < 70), $urandom, 16'($urandom),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 5));
    end
    idle(3);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 32'h55, 16'h0055, 1'b0, 1'b0, 1'b0);
    #1 RST_N = 1'b0;
    #1;
    check("async_valid", 64'(OUT_VALID), 64'd0);
    check("async_ctrl", 64'(OUT_CTRL), 64'd0);
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #2;
    RST_N = 1'b1;
    idle(4);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
